// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and helpers for the taint-tracked multiplier job sequencer
package mul_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        ERR   = 3'd4
    } state_e;

    function automatic int timeout_default(input int width);
        return 2 * width + 8;
    endfunction

    function automatic logic taint_or(input logic a, input logic b);
        return a | b;
    endfunction

endpackage

// File: rtl/mul_seq_timeout_ctr_taint.sv
// rtl/mul_seq_timeout_ctr_taint.sv - WAIT-cycle timeout counter with taint pass-through
module mul_seq_timeout_ctr_taint #(
    parameter int TIMEOUT = 24,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic taint,
    output logic expire,
    output logic expire_t
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the WAIT cycle whose increment brings the count to TIMEOUT.
    assign expire   = en && (cnt == CW'(TIMEOUT - 1));
    assign expire_t = taint;

endmodule

// File: rtl/mul_job_sequencer_taint.sv
// rtl/mul_job_sequencer_taint.sv - operand issue / product capture sequencer with word-level taint
module mul_job_sequencer_taint
    import mul_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = timeout_default(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_valid_t,
    output logic               in_ready,
    output logic               in_ready_t,
    input  logic [WIDTH-1:0]   op_a,
    input  logic               op_a_t,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               op_b_t,
    output logic               mul_start,
    output logic               mul_start_t,
    output logic [WIDTH-1:0]   mul_multiplier,
    output logic               mul_multiplier_t,
    output logic [WIDTH-1:0]   mul_multiplicand,
    output logic               mul_multiplicand_t,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic               mul_product_t,
    input  logic               mul_done,
    input  logic               mul_done_t,
    output logic               out_valid,
    output logic               out_valid_t,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_product_t,
    input  logic               out_ready,
    input  logic               out_ready_t,
    output logic               err,
    output logic               err_t
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e             state;
    state_e             state_nxt;
    logic               state_t;
    logic               state_t_nxt;
    logic               live;
    logic               seen_low;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               a_t_q;
    logic               b_t_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               prod_t_q;
    logic               expire;
    logic               expire_t;
    logic               done_ok;
    logic               accept;

    // A done level carried over from the previous job only counts once it has dropped.
    assign done_ok = mul_done && seen_low;
    assign accept  = live && in_valid;

    mul_seq_timeout_ctr_taint #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == ISSUE),
        .en       (state == WAIT),
        .taint    (state_t),
        .expire   (expire),
        .expire_t (expire_t)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            state_t <= 1'b0;
            live    <= 1'b0;
        end else begin
            state   <= state_nxt;
            state_t <= state_t_nxt;
            live    <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        state_t_nxt = state_t;
        case (state)
            IDLE: begin
                if (live) state_t_nxt = taint_or(state_t, in_valid_t);
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                state_t_nxt = taint_or(taint_or(state_t, mul_done_t), expire_t);
                if (done_ok)     state_nxt = HOLD;
                else if (expire) state_nxt = ERR;
            end
            HOLD: begin
                state_t_nxt = taint_or(state_t, out_ready_t);
                if (out_ready) state_nxt = IDLE;
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready           = live && (state == IDLE);
        mul_start          = (state == ISSUE);
        out_valid          = (state == HOLD);
        err                = (state == ERR);
        in_ready_t         = state_t;
        mul_start_t        = state_t;
        out_valid_t        = state_t;
        err_t              = state_t;
        mul_multiplier     = a_q;
        mul_multiplicand   = b_q;
        mul_multiplier_t   = taint_or(a_t_q, state_t);
        mul_multiplicand_t = taint_or(b_t_q, state_t);
        out_product        = prod_q;
        out_product_t      = prod_t_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            a_t_q    <= 1'b0;
            b_t_q    <= 1'b0;
            prod_q   <= '0;
            prod_t_q <= 1'b0;
            seen_low <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                a_q   <= op_a;
                b_q   <= op_b;
                a_t_q <= op_a_t;
                b_t_q <= op_b_t;
            end
            if (state == ISSUE) seen_low <= ~mul_done;
            if (state == WAIT && !mul_done) seen_low <= 1'b1;
            // Capture taint includes this edge's control taint, since the capture itself read mul_done_t.
            if (state == WAIT && done_ok) begin
                prod_q   <= mul_product;
                prod_t_q <= taint_or(mul_product_t, state_t_nxt);
            end
        end
    end

endmodule

// File: tb/tb_mul_job_sequencer_taint.sv
// tb/tb_mul_job_sequencer_taint.sv - directed self-checking bench for mul_job_sequencer_taint
module tb_mul_job_sequencer_taint;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid, in_valid_t, in_ready, in_ready_t;
    logic [W-1:0] op_a, op_b;
    logic         op_a_t, op_b_t;
    logic         mul_start, mul_start_t;
    logic [W-1:0] mul_multiplier, mul_multiplicand;
    logic         mul_multiplier_t, mul_multiplicand_t;
    logic [2*W-1:0] mul_product;
    logic         mul_product_t, mul_done, mul_done_t;
    logic         out_valid, out_valid_t;
    logic [2*W-1:0] out_product;
    logic         out_product_t, out_ready, out_ready_t;
    logic         err, err_t;

    int tests = 0;
    int fails = 0;

    mul_job_sequencer_taint #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_valid_t(in_valid_t),
        .in_ready(in_ready), .in_ready_t(in_ready_t),
        .op_a(op_a), .op_a_t(op_a_t), .op_b(op_b), .op_b_t(op_b_t),
        .mul_start(mul_start), .mul_start_t(mul_start_t),
        .mul_multiplier(mul_multiplier), .mul_multiplier_t(mul_multiplier_t),
        .mul_multiplicand(mul_multiplicand), .mul_multiplicand_t(mul_multiplicand_t),
        .mul_product(mul_product), .mul_product_t(mul_product_t),
        .mul_done(mul_done), .mul_done_t(mul_done_t),
        .out_valid(out_valid), .out_valid_t(out_valid_t),
        .out_product(out_product), .out_product_t(out_product_t),
        .out_ready(out_ready), .out_ready_t(out_ready_t),
        .err(err), .err_t(err_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        op_a = a; op_b = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 0; in_valid_t = 0; op_a = '0; op_a_t = 0; op_b = '0; op_b_t = 0;
        mul_product = '0; mul_product_t = 0; mul_done = 0; mul_done_t = 0;
        out_ready = 0; out_ready_t = 0;
        #2;
        chk("rst_outs", {in_ready, mul_start, out_valid, err}, 4'b0000);
        chk("rst_data", {mul_multiplier, mul_multiplicand, out_product}, 32'h0);
        chk("rst_taint", {in_ready_t, mul_start_t, out_valid_t, err_t, out_product_t}, 5'b0);
        #10 rst = 1'b1;
        tick();
        chk("rel_in_ready", in_ready, 1'b1);

        // 1: untainted 13*11, done after 17 WAIT cycles
        issue(8'd13, 8'd11);
        chk("t1_start", {mul_start, in_ready}, 2'b10);
        chk("t1_ops", {mul_multiplier, mul_multiplicand}, {8'd13, 8'd11});
        tick();
        chk("t1_start_pulse", mul_start, 1'b0);
        repeat (16) tick();
        chk("t1_no_out_yet", out_valid, 1'b0);
        mul_product = 16'd143; mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_product", out_product, 16'd143);
        chk("t1_taints", {in_ready_t, mul_start_t, out_valid_t, err_t, out_product_t,
                          mul_multiplier_t, mul_multiplicand_t}, 7'b0);
        tick();
        chk("t1_hold", {out_valid, out_product}, {1'b1, 16'd143});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_back_idle", {in_ready, out_valid}, 2'b10);

        // 2: op_a tainted only
        op_a_t = 1'b1;
        issue(8'd5, 8'd7);
        op_a_t = 1'b0; op_a = 8'd99;
        chk("t2_op_taints", {mul_multiplier_t, mul_multiplicand_t, in_ready_t}, 3'b100);
        tick();
        chk("t2_op_hold", mul_multiplier, 8'd5);
        mul_product = 16'd35; mul_product_t = 1'b1; mul_done = 1'b1;
        tick();
        mul_done = 1'b0; mul_product_t = 1'b0;
        chk("t2_product", {out_valid, out_product, out_product_t}, {1'b1, 16'd35, 1'b1});
        chk("t2_state_t", {out_valid_t, in_ready_t}, 2'b00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2_idle_taint", {in_ready, in_ready_t}, 2'b10);

        // 3: mul_done_t in WAIT makes state taint sticky
        issue(8'd2, 8'd3);
        tick();
        mul_done_t = 1'b1;
        tick();
        mul_done_t = 1'b0;
        chk("t3_state_t", in_ready_t, 1'b1);
        mul_product = 16'd6; mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        chk("t3_hold_taint", {out_valid, out_valid_t, out_product_t}, 3'b111);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_idle_taint", {in_ready, in_ready_t}, 2'b11);
        issue(8'd4, 8'd5);
        tick();
        mul_product = 16'd20; mul_done = 1'b1;
        tick();
        chk("t3_job2", {out_product, out_product_t, mul_multiplier_t}, {16'd20, 1'b1, 1'b1});

        // 4: done held high from previous job is not a completion
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        issue(8'd6, 8'd7);
        tick();
        chk("t4_stale_ignored", out_valid, 1'b0);
        repeat (2) tick();
        chk("t4_still_wait", {out_valid, out_product}, {1'b0, 16'd20});
        mul_done = 1'b0;
        tick();
        mul_product = 16'd42; mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        chk("t4_new_product", {out_valid, out_product}, {1'b1, 16'd42});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 6: async reset in WAIT, then in HOLD
        issue(8'd1, 8'd1);
        tick();
        #3 rst = 1'b0;
        #1;
        chk("t6_wait_rst", {in_ready, mul_start, out_valid, err, mul_multiplier}, 12'h0);
        chk("t6_wait_rst_t", {in_ready_t, mul_multiplier_t}, 2'b00);
        #2 rst = 1'b1;
        tick();
        chk("t6_wait_rel", {in_ready, in_ready_t}, 2'b10);
        issue(8'd3, 8'd3);
        tick();
        mul_product = 16'd9; mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        chk("t6_hold", {out_valid, out_product}, {1'b1, 16'd9});
        #3 rst = 1'b0;
        #1;
        chk("t6_hold_rst", {out_valid, out_product}, 17'h0);
        #2 rst = 1'b1;
        tick();
        chk("t6_hold_rel", {in_ready, out_valid, in_ready_t}, 3'b100);

        // 5: timeout after 24 WAIT cycles
        issue(8'd9, 8'd9);
        tick();
        repeat (23) tick();
        chk("t5_before_to", {err, in_ready}, 2'b00);
        tick();
        chk("t5_err", {err, in_ready, out_valid}, 3'b100);
        in_valid = 1'b1; mul_done = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0; mul_done = 1'b0;
        chk("t5_absorbing", {err, in_ready, out_valid, err_t}, 4'b1000);
        #3 rst = 1'b0;
        #1;
        chk("t5_rst_clears", err, 1'b0);
        #2 rst = 1'b1;
        tick();
        chk("t5_rel", {in_ready, err}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_job_sequencer_taint.md
Name: mul_job_sequencer_taint

Overview:
Front/back-end sequencer wrapped around the constant-time taint-tracked multiplier. It accepts operand pairs over a valid/ready handshake and drives the multiplier's start, multiplier and multiplicand inputs. It waits for productDone, captures the product and presents it on a valid/ready result port. Every data and control signal carries a word-level taint bit; taint through control decisions is tracked in a sticky state-taint register.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH.
TIMEOUT, 2*WIDTH+8, max cycles in WAIT before ERR.
CW, $clog2(TIMEOUT+1), timeout counter width (derived localparam).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
in_valid / in_valid_t  in  1/1  operand pair valid, plus taint.
in_ready / in_ready_t  out  1/1  sequencer can accept, plus taint.
op_a / op_a_t  in  WIDTH/1  multiplier operand, plus taint.
op_b / op_b_t  in  WIDTH/1  multiplicand operand, plus taint.
mul_start / mul_start_t  out  1/1  start to multiplier, plus taint.
mul_multiplier / mul_multiplier_t  out  WIDTH/1  latched op_a, plus taint.
mul_multiplicand / mul_multiplicand_t  out  WIDTH/1  latched op_b, plus taint.
mul_product / mul_product_t  in  2*WIDTH/1  multiplier product, plus taint.
mul_done / mul_done_t  in  1/1  multiplier productDone, plus taint.
out_valid / out_valid_t  out  1/1  result valid, plus taint.
out_product / out_product_t  out  2*WIDTH/1  captured product, plus taint.
out_ready / out_ready_t  in  1/1  consumer accepts, plus taint.
err / err_t  out  1/1  sticky timeout error, plus taint.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs, operand/product registers, taint registers, the counter and seen_low are 0.
- States: IDLE, ISSUE, WAIT, HOLD, ERR (2-bit+ encoding, one extra code).
- IDLE:
  - in_ready=1.
  - If in_valid: latch op_a/op_b and their taints into mul_* registers, go to ISSUE.
- ISSUE:
  - mul_start=1 for exactly one cycle.
  - Counter cleared; seen_low <= ~mul_done.
  - Go to WAIT.
- WAIT:
  - seen_low sets when mul_done=0.
  - The first mul_done=1 with seen_low=1 (level left over from the previous job is ignored) captures mul_product and mul_product_t into out_product/out_product_t, then goes to HOLD.
  - Counter increments every WAIT cycle. Counter==TIMEOUT without completion: go to ERR and set err.
- HOLD:
  - out_valid=1; out_product stable.
  - When out_ready=1: go to IDLE.
  - No bypass: the earliest next in_ready is the cycle after the handshake.
- ERR: absorbing until reset; in_ready=0, out_valid=0, err=1.
- in_ready, mul_start and out_valid are Moore outputs of the registered state.
- Latency: from in_valid accepted in IDLE, mul_start is high 1 cycle later. out_valid is high 1 cycle after the qualifying mul_done edge.
- Operand registers hold while not in IDLE; op_a/op_b changes outside IDLE are ignored.
- Taint rules (word-level OR; conservative):
  - state_t: sticky, cleared only by reset. Set on any clock where the taken (or not-taken) transition condition reads a tainted signal: in_valid_t in IDLE, mul_done_t in WAIT, out_ready_t in HOLD.
  - in_ready_t, mul_start_t, out_valid_t, err_t = state_t.
  - mul_multiplier_t = latched op_a_t | state_t; mul_multiplicand_t likewise from op_b_t.
  - out_product_t = captured mul_product_t | state_t (evaluated at the capture edge and held).
  - Counter taint is folded into state_t; the counter depends only on state.
- Reset mid-operation: immediate return to IDLE with all taints cleared. A multiplier still running is not this block's concern; seen_low guards the next job.

Decomposition:
- Shared package mul_seq_pkg: state enum (IDLE/ISSUE/WAIT/HOLD/ERR), taint OR helper function, TIMEOUT default expression.
- One natural sub-module: mul_seq_timeout_ctr_taint (CW-bit counter with clear/enable/expire, taint in, taint out).
- FSM, operand registers and product capture stay in the top module.

Test Plan:
1. WIDTH=8, all taints 0: op_a=13, op_b=11, in_valid for 1 cycle -> mul_start pulses 1 cycle after acceptance; mock done after 17 cycles with product=143 -> out_valid next cycle, out_product=143, every *_t=0.
2. op_a_t=1 only -> mul_multiplier_t=1, mul_multiplicand_t=0, out_product_t follows mock mul_product_t (1); state_t stays 0, so in_ready_t=0 and out_valid_t=0.
3. mul_done_t=1 during WAIT -> state_t sets; in_ready_t, out_valid_t and out_product_t are 1 and remain 1 after returning to IDLE and completing a second untainted job.
4. mul_done held high from the previous job into a new WAIT -> no capture until done drops and rises again; out_product equals the new product, not the stale one.
5. mul_done never asserts -> after TIMEOUT=24 WAIT cycles (WIDTH=8), err=1, in_ready=0, out_valid=0. Only rst=0 clears err.
6. rst asserted in WAIT and in HOLD (out_ready=0) -> all outputs 0 asynchronously; after release, in_ready=1 next edge and state_t=0.
